spmm_row_scheduler: RTL and testbench
=====================================

Name: spmm_row_scheduler

Overview:
Control-side sequencer for the SpMM PE array. It accepts one CSR row-pointer vector per LHS tile and walks the nonzero stream in chunks of N. For every chunk it emits the reduction-unit controls:
- per-lane split bits,
- halo (carry-in) clear,
- an ordered list of completed rows, each with its output slot and an empty-row flag.

It sits between the LHS loader and the PE/reduction datapath. It replaces ad-hoc per-PE pointer tracking with one shared, back-pressurable control stream.

Parameters:
N, 16, lanes per chunk and rows per tile (power of two, >=4)
LGN, $clog2(N), lane/row index width
PTR_W, 2*$clog2(N)+1, row-pointer width (holds 0..N*N)

Ports:
clock  in  1  clock
reset  in  1  reset, asynchronous, active-high
cfg_valid  in  1  pointer vector offered
cfg_ready  out  1  scheduler can accept a pointer vector
cfg_ptr  in  N*PTR_W  ptr[r] = cumulative nonzero count of rows 0..r (exclusive end); r at bits [r*PTR_W +: PTR_W]
ctl_valid  out  1  chunk control word valid
ctl_ready  in  1  datapath consumes control word
ctl_chunk  out  LGN  chunk index c
ctl_last  out  1  this is the final chunk of the tile
ctl_split  out  N  bit k=1: nonzero c*N+k ends a nonempty row
ctl_halo_clear  out  1  halo_in must be zeroed for this chunk
ctl_cnt  out  LGN+1  number of valid row entries (0..N)
ctl_slot  out  N*LGN  entry j: lane holding row j's final partial sum
ctl_row  out  N*LGN  entry j: row id
ctl_zero  out  N  entry j: row is empty, output 0
done  out  1  one-cycle pulse, tile finished
err  out  1  pointer vector rejected; valid with done, held until next cfg accept
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE.
  - All outputs 0, except cfg_ready=1.
  - Reset mid-operation aborts the tile. No done pulse is generated.
- States: IDLE, CHECK, ISSUE, DONE.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid&&cfg_ready, register ptr, clear err, go to CHECK.
- CHECK (1 cycle):
  - Validate ptr[r]>=ptr[r-1] for all r, and ptr[N-1]<=N*N.
  - Fail: err<=1, go to DONE. No ctl_valid is ever raised.
  - Pass: nnz=ptr[N-1]; num_chunks=max(1, ceil(nnz/N)); c<=0; load chunk-0 word; go to ISSUE.
  - First ctl_valid is therefore high in the 2nd cycle after the cfg handshake edge.
- ISSUE:
  - ctl_valid=1.
  - Payload is registered and held stable while ctl_valid&&!ctl_ready.
  - On ctl_ready the next word is presented the following cycle. Throughput is 1 chunk/cycle.
  - After the handshake of the chunk with ctl_last=1, go to DONE. ctl_valid drops the same edge.
- DONE:
  - done=1 for exactly one cycle, with err valid.
  - Return to IDLE.
- Row-to-chunk mapping:
  - owner(r) = 0 if ptr[r]==0, else (ptr[r]-1)/N.
  - slot(r) = 0 if ptr[r]==0, else (ptr[r]-1)%N.
  - empty(r) = (ptr[r]==(r==0 ? 0 : ptr[r-1])).
- Chunk c word:
  - Entries are the rows with owner(r)==c, in ascending r. ctl_cnt is their number.
  - Entries j>=cnt have slot, row and zero all =0.
  - ctl_split[k]=1 iff some nonempty row has ptr[r]==c*N+k+1.
  - ctl_halo_clear=1 iff c==0, or some nonempty row has ptr[r]==c*N.
  - ctl_last = (c==num_chunks-1).
- Lanes beyond nnz in the last chunk have split=0. The datapath ignores them.
- nnz==0: exactly one chunk with all N rows as zero entries, split=0, halo_clear=1.
- cfg_valid while busy is ignored (cfg_ready=0).

Test Plan:
- N=4, ptr={2,2,5,9} -> 3 chunks, each word as below:
  - c0: split=0010, halo_clear=1, cnt=2, entries (row0,slot1,zero0),(row1,slot1,zero1).
  - c1: split=0001, halo_clear=0, cnt=1, (row2,slot0).
  - c2: split=0001, halo_clear=0, cnt=1, (row3,slot0), last=1.
  - done pulses the cycle after c2 handshake, err=0.
- N=4, ptr={4,8,12,16} -> 4 chunks, each split=1000, halo_clear=1, cnt=1, (row c, slot3); last only on c3.
- N=4, ptr={0,0,0,0} -> single chunk: cnt=4, all zero=1, slots 0, split=0000, halo_clear=1, last=1.
- ptr={3,2,5,6} or ptr[3]=17 (N=4) -> ctl_valid never asserts; done=1 and err=1 two cycles after cfg edge; err stays 1 until next cfg accept.
- Backpressure: ctl_ready low 3 cycles during c1 of first case -> payload bit-identical across stall; no chunk skipped or duplicated; cfg_ready stays 0.
- Reset asserted asynchronously during ISSUE c1 -> outputs 0 immediately, cfg_ready=1 after release, no done; a new cfg starts cleanly at c0.

Source files
------------

// File: rtl/spmm_row_scheduler.sv
// SpMM row scheduler: turns one CSR row-pointer vector per LHS tile
// into a back-pressurable stream of per-chunk reduction controls.
`timescale 1ns/1ps
module spmm_row_scheduler #(
    parameter int N     = 16,
    parameter int LGN   = $clog2(N),
    parameter int PTR_W = 2*$clog2(N)+1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [N*PTR_W-1:0] cfg_ptr,
    output logic               ctl_valid,
    input  logic               ctl_ready,
    output logic [LGN-1:0]     ctl_chunk,
    output logic               ctl_last,
    output logic [N-1:0]       ctl_split,
    output logic               ctl_halo_clear,
    output logic [LGN:0]       ctl_cnt,
    output logic [N*LGN-1:0]   ctl_slot,
    output logic [N*LGN-1:0]   ctl_row,
    output logic [N-1:0]       ctl_zero,
    output logic               done,
    output logic               err,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, DONE} state_t;

    localparam logic [PTR_W-1:0] MAX_NNZ = PTR_W'(N*N);

    state_t state, state_next;

    logic [PTR_W-1:0] ptr [N];
    logic             ptr_ok;
    logic [LGN-1:0]   last_c;

    logic [LGN-1:0]   w_c;
    logic [PTR_W-1:0] w_base;
    logic [N-1:0]     w_split;
    logic             w_halo;
    logic [LGN:0]     w_cnt;
    logic [N*LGN-1:0] w_slot;
    logic [N*LGN-1:0] w_row;
    logic [N-1:0]     w_zero;
    logic [LGN-1:0]   e_slot [N];
    logic [LGN-1:0]   e_row [N];

    logic [PTR_W-1:0] prev;
    logic [PTR_W-1:0] pm1;
    logic [LGN-1:0]   own;
    logic [LGN-1:0]   slot;
    logic             empty;

    logic             load;

    always_comb begin
        ptr_ok = (ptr[N-1] <= MAX_NNZ);
        for (int r = 1; r < N; r++) begin
            if (ptr[r] < ptr[r-1]) ptr_ok = 1'b0;
        end
        last_c = '0;
        if (ptr[N-1] != '0) last_c = LGN'((ptr[N-1] - 1'b1) >> LGN);
    end

    // Next word: chunk 0 while checking, otherwise the chunk after the one shown.
    always_comb begin
        w_c     = (state == ISSUE) ? ctl_chunk + 1'b1 : '0;
        w_base  = PTR_W'(w_c) << LGN;
        w_split = '0;
        w_halo  = (w_c == '0);
        w_cnt   = '0;
        w_zero  = '0;
        w_slot  = '0;
        w_row   = '0;
        prev    = '0;
        pm1     = '0;
        own     = '0;
        slot    = '0;
        empty   = 1'b0;
        for (int j = 0; j < N; j++) begin
            e_slot[j] = '0;
            e_row[j]  = '0;
        end
        for (int r = 0; r < N; r++) begin
            empty = (ptr[r] == prev);
            pm1   = ptr[r] - 1'b1;
            own   = (ptr[r] == '0) ? '0 : LGN'(pm1 >> LGN);
            slot  = (ptr[r] == '0) ? '0 : pm1[LGN-1:0];
            if (own == w_c) begin
                e_slot[w_cnt[LGN-1:0]] = slot;
                e_row[w_cnt[LGN-1:0]]  = LGN'(r);
                w_zero[w_cnt[LGN-1:0]] = empty;
                if (!empty) w_split[slot] = 1'b1;
                w_cnt = w_cnt + 1'b1;
            end
            // A row closing exactly at the previous chunk boundary leaves no carry.
            if (!empty && ptr[r] == w_base) w_halo = 1'b1;
            prev = ptr[r];
        end
        for (int j = 0; j < N; j++) begin
            w_slot[j*LGN +: LGN] = e_slot[j];
            w_row[j*LGN +: LGN]  = e_row[j];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        cfg_ready  = 1'b0;
        ctl_valid  = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) state_next = CHECK;
            end
            CHECK: begin
                load       = ptr_ok;
                state_next = ptr_ok ? ISSUE : DONE;
            end
            ISSUE: begin
                ctl_valid = 1'b1;
                if (ctl_ready) begin
                    load = !ctl_last;
                    if (ctl_last) state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < N; r++) ptr[r] <= '0;
            err            <= 1'b0;
            ctl_chunk      <= '0;
            ctl_last       <= 1'b0;
            ctl_split      <= '0;
            ctl_halo_clear <= 1'b0;
            ctl_cnt        <= '0;
            ctl_slot       <= '0;
            ctl_row        <= '0;
            ctl_zero       <= '0;
        end else begin
            if (state == IDLE && cfg_valid) begin
                for (int r = 0; r < N; r++) ptr[r] <= cfg_ptr[r*PTR_W +: PTR_W];
                err <= 1'b0;
            end
            if (state == CHECK && !ptr_ok) err <= 1'b1;
            if (load) begin
                ctl_chunk      <= w_c;
                ctl_last       <= (w_c == last_c);
                ctl_split      <= w_split;
                ctl_halo_clear <= w_halo;
                ctl_cnt        <= w_cnt;
                ctl_slot       <= w_slot;
                ctl_row        <= w_row;
                ctl_zero       <= w_zero;
            end
        end
    end

endmodule

// File: tb/tb_spmm_row_scheduler.sv
// Scoreboard bench for spmm_row_scheduler at N=4: expected chunk words
// are queued at cfg time and compared as the DUT hands them off.
`timescale 1ns/1ps
module tb_spmm_row_scheduler;

    localparam int N     = 4;
    localparam int LGN   = 2;
    localparam int PTR_W = 5;

    logic               clock;
    logic               reset;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [N*PTR_W-1:0] cfg_ptr;
    logic               ctl_valid;
    logic               ctl_ready;
    logic [LGN-1:0]     ctl_chunk;
    logic               ctl_last;
    logic [N-1:0]       ctl_split;
    logic               ctl_halo_clear;
    logic [LGN:0]       ctl_cnt;
    logic [N*LGN-1:0]   ctl_slot;
    logic [N*LGN-1:0]   ctl_row;
    logic [N-1:0]       ctl_zero;
    logic               done;
    logic               err;
    logic               busy;

    spmm_row_scheduler #(.N(N), .LGN(LGN), .PTR_W(PTR_W)) dut (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ptr(cfg_ptr),
        .ctl_valid(ctl_valid), .ctl_ready(ctl_ready),
        .ctl_chunk(ctl_chunk), .ctl_last(ctl_last), .ctl_split(ctl_split),
        .ctl_halo_clear(ctl_halo_clear), .ctl_cnt(ctl_cnt),
        .ctl_slot(ctl_slot), .ctl_row(ctl_row), .ctl_zero(ctl_zero),
        .done(done), .err(err), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [30:0] sb [$];
    logic [30:0] obs;
    logic [30:0] held;
    logic        stalled = 1'b0;

    assign obs = {ctl_chunk, ctl_last, ctl_split, ctl_halo_clear,
                  ctl_cnt, ctl_slot, ctl_row, ctl_zero};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [30:0] model(input int p[4], input int c);
        int nch;
        int pv;
        int own;
        int j;
        bit ne;
        logic [3:0] split;
        logic       halo;
        logic [7:0] sl;
        logic [7:0] rw;
        logic [3:0] z;
        nch   = (p[3] == 0) ? 1 : (p[3] + 3) / 4;
        split = '0;
        halo  = (c == 0);
        sl    = '0;
        rw    = '0;
        z     = '0;
        j     = 0;
        pv    = 0;
        for (int r = 0; r < 4; r++) begin
            ne = (p[r] != pv);
            for (int k = 0; k < 4; k++)
                if (ne && p[r] == c*4 + k + 1) split[k] = 1'b1;
            if (ne && p[r] == c*4) halo = 1'b1;
            own = (p[r] == 0) ? 0 : (p[r] - 1) / 4;
            if (own == c) begin
                sl[j*2 +: 2] = 2'((p[r] == 0) ? 0 : (p[r] - 1) % 4);
                rw[j*2 +: 2] = 2'(r);
                z[j]         = !ne;
                j++;
            end
            pv = p[r];
        end
        return {2'(c), (c == nch - 1), split, halo, 3'(j), sl, rw, z};
    endfunction

    // Handoff monitor: every accepted word is scored, stalled words must hold.
    always @(negedge clock) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (ctl_valid) begin
                check("cfg_ready_busy", cfg_ready, 0);
                if (stalled) check("stall_hold", obs, held);
                if (ctl_ready) begin
                    check("word", obs, (sb.size() != 0) ? sb.pop_front() : '1);
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = obs;
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic drive_cfg(input int p[4]);
        int t;
        t = 0;
        while (!cfg_ready && t < 50) begin
            @(posedge clock); #1;
            t++;
        end
        check("cfg_ready_wait", cfg_ready, 1);
        for (int r = 0; r < 4; r++) cfg_ptr[r*PTR_W +: PTR_W] = 5'(p[r]);
        cfg_valid = 1'b1;
        @(posedge clock); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic push_words(input int p[4]);
        int nch;
        nch = (p[3] == 0) ? 1 : (p[3] + 3) / 4;
        for (int c = 0; c < nch; c++) sb.push_back(model(p, c));
    endtask

    task automatic run_tile(input int p[4]);
        int d0;
        int t;
        push_words(p);
        d0 = done_cnt;
        drive_cfg(p);
        @(negedge clock);
        check("lat_check_cycle", ctl_valid, 0);
        @(negedge clock);
        check("lat_first_valid", ctl_valid, 1);
        t = 0;
        while (done_cnt == d0 && t < 100) begin
            @(posedge clock); #2;
            t++;
        end
        check("done_count", done_cnt - d0, 1);
        check("err_clear", err, 0);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic run_bad(input int p[4]);
        drive_cfg(p);
        @(negedge clock);
        check("bad_valid0", ctl_valid, 0);
        check("bad_done0", done, 0);
        @(negedge clock);
        check("bad_done", done, 1);
        check("bad_err", err, 1);
        check("bad_valid1", ctl_valid, 0);
        repeat (3) @(negedge clock);
        check("bad_err_held", err, 1);
        check("bad_done_once", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p[4];
        int t;
        int d0;
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_ptr   = '0;
        ctl_ready = 1'b1;
        #12;
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_ctl_valid", ctl_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_payload", obs, 0);
        @(negedge clock);
        reset = 1'b0;

        // Three chunks with a 3-cycle stall while chunk 1 is shown.
        p = '{2, 2, 5, 9};
        fork
            run_tile(p);
            begin
                t = 0;
                do begin
                    @(posedge clock); #1;
                    t++;
                end while (!(ctl_valid && ctl_chunk == 2'd1) && t < 50);
                check("stall_reach_c1", ctl_chunk, 1);
                ctl_ready = 1'b0;
                repeat (3) @(posedge clock);
                #1 ctl_ready = 1'b1;
            end
        join

        p = '{4, 8, 12, 16};
        run_tile(p);
        p = '{0, 0, 0, 0};
        run_tile(p);
        p = '{3, 2, 5, 6};
        run_bad(p);
        p = '{1, 2, 3, 17};
        run_bad(p);
        p = '{0, 1, 1, 4};
        run_tile(p);

        // Abort mid-tile while chunk 1 is on the bus.
        p = '{2, 2, 5, 9};
        push_words(p);
        d0 = done_cnt;
        drive_cfg(p);
        t = 0;
        do begin
            @(posedge clock); #1;
            t++;
        end while (!(ctl_valid && ctl_chunk == 2'd1) && t < 50);
        check("abort_reach_c1", ctl_chunk, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_valid", ctl_valid, 0);
        check("abort_payload", obs, 0);
        check("abort_busy", busy, 0);
        check("abort_cfg_ready", cfg_ready, 1);
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_ready_after", cfg_ready, 1);
        p = '{2, 2, 5, 9};
        run_tile(p);

        for (int n = 0; n < 4; n++) begin
            p[0] = $urandom_range(0, 4);
            for (int r = 1; r < 4; r++) p[r] = p[r-1] + $urandom_range(0, 5);
            if (p[3] > 16) p[3] = 16;
            for (int r = 2; r >= 0; r--) if (p[r] > p[r+1]) p[r] = p[r+1];
            run_tile(p);
        end

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
